// File: rtl/adder_sched_pkg.sv
// Shared types and width helpers for the adder round-robin scheduler.
package adder_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } sched_state_e;

  function automatic int sum_width(input int w1, input int w2);
    return ((w1 > w2) ? w1 : w2) + 1;
  endfunction

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Round-robin grant: first asserted request at or after ptr, scanning upward with wrap.
module rr_grant #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  int unsigned     j;
  logic [ID_W-1:0] k;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    k   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j = 32'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      k = ID_W'(j);
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Shares one registered adder among N_REQ requesters with a single response port.
// ADDER_RR_SCHEDULER_FAIR_EN selects round-robin; otherwise fixed lowest-index priority.
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter int  N_REQ     = 4,
  parameter int  WIDTH_1   = 8,
  parameter int  WIDTH_2   = 8,
  localparam int WIDTH_OUT = sum_width(WIDTH_1, WIDTH_2),
  localparam int ID_W      = id_width(N_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                req_valid,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ-1:0][WIDTH_1-1:0]   req_a,
  input  logic [N_REQ-1:0][WIDTH_2-1:0]   req_b,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [WIDTH_OUT-1:0]            rsp_sum,
  output logic [ID_W-1:0]                 rsp_id
);

  sched_state_e     state, state_next;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  gidx;
  logic [N_REQ-1:0] gnt;
  logic             any, accept, xfer, drain;

  rr_grant #(
    .N_REQ(N_REQ),
    .ID_W (ID_W)
  ) u_grant (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(gidx),
    .any(any)
  );

  // A slot opens when empty or when the held result drains this same cycle.
  assign accept = !rst && ((state == IDLE) || rsp_ready);
  assign xfer   = accept && any;
  assign drain  = (state == FULL) && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (xfer) state_next = FULL;
      FULL:    if (drain && !xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = (state == FULL);
    req_ready = accept ? gnt : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_sum <= '0;
      rsp_id  <= '0;
    end else if (xfer) begin
      rsp_sum <= WIDTH_OUT'(req_a[gidx]) + WIDTH_OUT'(req_b[gidx]);
      rsp_id  <= gidx;
    end
  end

`ifdef ADDER_RR_SCHEDULER_FAIR_EN
  always_ff @(posedge clk) begin
    if (rst)       rr_ptr <= '0;
    else if (xfer) rr_ptr <= (32'(gidx) == N_REQ - 1) ? '0 : gidx + ID_W'(1);
  end
`else
  assign rr_ptr = '0;
`endif

endmodule
